// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port, fixed-latency memory between
// the instruction-fetch (IF) port and the data-memory (DM) port.
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,

  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ready,

  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,

  output logic            stall_if,
  output logic            stall_dm
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {P_IF = 1'b0, P_DM = 1'b1} port_t;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_t            r_state;
  state_t            w_state_next;
  port_t             r_grant;
  port_t             r_last_grant;
  port_t             w_grant_next;
  logic              w_take;
  logic              w_lat_done;
  logic              w_if_ready;
  logic              w_dm_ready;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_we;
  logic [XLEN-1:0]   r_if_rdata;
  logic [XLEN-1:0]   r_dm_rdata;

  assign w_lat_done = (r_cnt == LAT);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_grant_next = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (if_req || dm_req) begin
          w_take       = 1'b1;
          w_state_next = S_ISSUE;
          if (if_req && dm_req)
            w_grant_next = (r_last_grant == P_IF) ? P_DM : P_IF;
          else
            w_grant_next = dm_req ? P_DM : P_IF;
        end
      end
      S_ISSUE: w_state_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (w_lat_done) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Access registers: latched at grant so mem_* never depend on live requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant      <= P_IF;
      r_last_grant <= P_IF;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_grant      <= w_grant_next;
            r_last_grant <= w_grant_next;
            if (w_grant_next == P_DM) begin
              r_addr  <= dm_addr;
              r_we    <= dm_we;
              r_wdata <= dm_we ? dm_wdata : '0;
            end else begin
              r_addr  <= if_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
            end
          end
        end
        S_ISSUE: r_cnt <= CNT_W'(1);
        S_WAIT: begin
          if (w_lat_done) begin
            if (r_grant == P_DM) r_dm_rdata <= mem_rdata;
            else                 r_if_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP:  r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign w_if_ready = (r_state == S_RESP) && (r_grant == P_IF);
  assign w_dm_ready = (r_state == S_RESP) && (r_grant == P_DM);

  assign if_ready  = w_if_ready;
  assign dm_ready  = w_dm_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

  assign mem_en    = (r_state == S_ISSUE);
  assign mem_we    = (r_state == S_ISSUE) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign stall_if  = if_req & ~w_if_ready;
  assign stall_dm  = dm_req & ~w_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one MEM_LAT=2 instance with a
// fixed-latency memory model, plus MEM_LAT=1 and MEM_LAT=15 instances for latency extremes.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;

  logic clk;
  logic rst;

  logic            if_req, dm_req, dm_we;
  logic [XLEN-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [XLEN-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic            if_ready, dm_ready, mem_en, mem_we, stall_if, stall_dm;

  logic            l1_dm_req, l15_dm_req;
  logic [XLEN-1:0] l1_mem_rdata, l15_mem_rdata;
  logic [XLEN-1:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata;
  logic [XLEN-1:0] l15_if_rdata, l15_dm_rdata, l15_mem_addr, l15_mem_wdata;
  logic            l1_if_ready, l1_dm_ready, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_dm;
  logic            l15_if_ready, l15_dm_ready, l15_mem_en, l15_mem_we, l15_stall_if, l15_stall_dm;

  int checks;
  int errors;

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LAT(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
  );

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .dm_req(l1_dm_req), .dm_we(1'b0), .dm_addr(32'h44), .dm_wdata(32'h0),
    .dm_rdata(l1_dm_rdata), .dm_ready(l1_dm_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .stall_if(l1_stall_if), .stall_dm(l1_stall_dm)
  );

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LAT(15), .CNT_W(4)) u_lat15 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(l15_if_rdata), .if_ready(l15_if_ready),
    .dm_req(l15_dm_req), .dm_we(1'b0), .dm_addr(32'h44), .dm_wdata(32'h0),
    .dm_rdata(l15_dm_rdata), .dm_ready(l15_dm_ready),
    .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr), .mem_wdata(l15_mem_wdata),
    .mem_rdata(l15_mem_rdata), .stall_if(l15_stall_if), .stall_dm(l15_stall_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read contents of the main memory: 0x100 holds an instruction, others are address-derived.
  function automatic logic [XLEN-1:0] mem_data(input logic [XLEN-1:0] addr);
    if (addr == 32'h100) return 32'h0050_0093;
    return {~addr[15:0], addr[15:0]};
  endfunction

  // Fixed-latency memory for u_dut: valid data only in the cycle issue+2, garbage otherwise.
  initial begin : mem_model
    int              k;
    logic            pend;
    logic [XLEN-1:0] pdata;
    k = 0;
    pend = 1'b0;
    pdata = '0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else if (mem_en && !mem_we) begin
        pend  = 1'b1;
        k     = 0;
        pdata = mem_data(mem_addr);
      end else if (pend) begin
        k++;
      end
      if (pend && k == 2) begin
        mem_rdata = pdata;
        pend = 1'b0;
      end else begin
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [4:0] got_ctl;
    rst = 1'b1;
    tick();
    tick();
    got_ctl = {mem_en, mem_we, if_ready, dm_ready, stall_if};
    checks++;
    if (got_ctl !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000", got_ctl);
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h exp 0 0", if_rdata, dm_rdata);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({mem_en, if_ready, dm_ready, l1_mem_en, l15_mem_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle got %b exp 00000", {mem_en, if_ready, dm_ready, l1_mem_en, l15_mem_en});
    end
  endtask

  task automatic test_fetch();
    logic [2:0] got;
    logic [2:0] exp;
    if_addr = 32'h100;
    if_req  = 1'b1;
    #1;
    for (int c = 0; c <= 5; c++) begin
      got = {mem_en, if_ready, stall_if};
      exp = {c == 1, c == 4, c <= 3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fetch_ctl cycle %0d got %b exp %b", c, got, exp);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 32'h100) begin
          errors++;
          $display("FAIL fetch_addr got %h exp 00000100", mem_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (if_rdata !== 32'h0050_0093) begin
          errors++;
          $display("FAIL fetch_data got %h exp 00500093", if_rdata);
        end
        if_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [3:0] got;
    logic [3:0] exp;
    dm_addr  = 32'h20;
    dm_wdata = 32'hDEAD_BEEF;
    dm_we    = 1'b1;
    dm_req   = 1'b1;
    #1;
    for (int c = 0; c <= 3; c++) begin
      got = {mem_en, mem_we, dm_ready, stall_dm};
      exp = {c == 1, c == 1, c == 2, c <= 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL store_ctl cycle %0d got %b exp %b", c, got, exp);
      end
      if (c == 1) begin
        checks++;
        if ({mem_addr, mem_wdata} !== {32'h20, 32'hDEAD_BEEF}) begin
          errors++;
          $display("FAIL store_bus got %h %h exp 00000020 deadbeef", mem_addr, mem_wdata);
        end
      end
      checks++;
      if ({if_rdata, dm_rdata} !== {32'h0050_0093, 32'h0}) begin
        errors++;
        $display("FAIL store_rdata_hold cycle %0d got %h %h exp 00500093 00000000", c, if_rdata, dm_rdata);
      end
      if (c == 2) begin
        dm_req = 1'b0;
        dm_we  = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_arbitration();
    int n;
    logic [1:0] exp_rdy;
    apply_reset();
    if_addr = 32'h200;
    dm_addr = 32'h300;
    dm_we   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    #1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (if_ready || dm_ready) begin
        exp_rdy = (n % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if ({if_ready, dm_ready} !== exp_rdy || c != 4 + 5 * n) begin
          errors++;
          $display("FAIL arb_grant access %0d got rdy %b at cycle %0d exp rdy %b at cycle %0d",
                   n, {if_ready, dm_ready}, c, exp_rdy, 4 + 5 * n);
        end
        checks++;
        if (n % 2 == 0 && dm_rdata !== 32'hFCFF_0300) begin
          errors++;
          $display("FAIL arb_dm_data access %0d got %h exp fcff0300", n, dm_rdata);
        end else if (n % 2 == 1 && if_rdata !== 32'hFDFF_0200) begin
          errors++;
          $display("FAIL arb_if_data access %0d got %h exp fdff0200", n, if_rdata);
        end
        n++;
        if (n == 6) begin
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
      tick();
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL arb_timeout got %0d accesses exp 6", n);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [1:0] got;
    logic [1:0] exp;
    dm_addr = 32'h44;
    dm_we   = 1'b0;
    dm_req  = 1'b1;
    tick();
    tick();
    #2;
    rst     = 1'b1;
    if_addr = 32'h100;
    if_req  = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0) begin
      errors++;
      $display("FAIL rst_async_ctl got %b exp 0000", {mem_en, mem_we, if_ready, dm_ready});
    end
    checks++;
    if ({mem_addr, if_rdata, dm_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL rst_async_regs got %h %h %h exp 0 0 0", mem_addr, if_rdata, dm_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({if_ready, dm_ready, mem_en} !== 3'b0) begin
        errors++;
        $display("FAIL rst_hold cycle %0d got %b exp 000", i, {if_ready, dm_ready, mem_en});
      end
    end
    rst = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      got = {if_ready, dm_ready};
      exp = {c == 9, c == 4};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rst_recover cycle %0d got %b exp %b", c, got, exp);
      end
      if (c == 4) begin
        checks++;
        if (dm_rdata !== 32'hFFBB_0044) begin
          errors++;
          $display("FAIL rst_recover_dm_data got %h exp ffbb0044", dm_rdata);
        end
        dm_req = 1'b0;
      end
      if (c == 9) begin
        checks++;
        if (if_rdata !== 32'h0050_0093) begin
          errors++;
          $display("FAIL rst_recover_if_data got %h exp 00500093", if_rdata);
        end
        if_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_latency_extremes();
    logic [2:0] got1, exp1, got15, exp15;
    l1_dm_req  = 1'b1;
    l15_dm_req = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      l1_mem_rdata  = (c == 2)  ? 32'hFFBB_0044 : 32'hBAD1_0000 + 32'(c);
      l15_mem_rdata = (c == 16) ? 32'hFFBB_0044 : 32'hBAD2_0000 + 32'(c);
      #1;
      got1  = {l1_mem_en, l1_dm_ready, l1_stall_dm};
      exp1  = {c == 1, c == 3, c <= 2};
      got15 = {l15_mem_en, l15_dm_ready, l15_stall_dm};
      exp15 = {c == 1, c == 17, c <= 16};
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL lat1_ctl cycle %0d got %b exp %b", c, got1, exp1);
      end
      checks++;
      if (got15 !== exp15) begin
        errors++;
        $display("FAIL lat15_ctl cycle %0d got %b exp %b", c, got15, exp15);
      end
      if (c == 1) begin
        checks++;
        if ({l1_mem_addr, l15_mem_addr, l1_mem_we, l15_mem_we} !== {32'h44, 32'h44, 2'b00}) begin
          errors++;
          $display("FAIL lat_issue got %h %h we %b exp 00000044 00000044 we 00",
                   l1_mem_addr, l15_mem_addr, {l1_mem_we, l15_mem_we});
        end
      end
      if (c == 3) begin
        checks++;
        if (l1_dm_rdata !== 32'hFFBB_0044) begin
          errors++;
          $display("FAIL lat1_data got %h exp ffbb0044", l1_dm_rdata);
        end
        l1_dm_req = 1'b0;
      end
      if (c == 17) begin
        checks++;
        if (l15_dm_rdata !== 32'hFFBB_0044) begin
          errors++;
          $display("FAIL lat15_data got %h exp ffbb0044", l15_dm_rdata);
        end
        l15_dm_req = 1'b0;
      end
      tick();
    end
    checks++;
    if ({l1_if_ready, l15_if_ready, l1_stall_if, l15_stall_if, l1_if_rdata, l15_if_rdata} !== 68'h0) begin
      errors++;
      $display("FAIL lat_if_quiet got %b %h %h exp 0000 0 0",
               {l1_if_ready, l15_if_ready, l1_stall_if, l15_stall_if}, l1_if_rdata, l15_if_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got;
    logic [1:0] exp;
    if_addr = 32'h400;
    if_req  = 1'b1;
    #1;
    for (int c = 0; c <= 10; c++) begin
      got = {mem_en, if_ready};
      exp = {c == 1 || c == 6, c == 4 || c == 9};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_ctl cycle %0d got %b exp %b", c, got, exp);
      end
      if (c == 1 || c == 6) begin
        checks++;
        if (mem_addr !== ((c == 1) ? 32'h400 : 32'h404)) begin
          errors++;
          $display("FAIL b2b_addr cycle %0d got %h exp %h", c, mem_addr, (c == 1) ? 32'h400 : 32'h404);
        end
      end
      if (c == 4) begin
        checks++;
        if (if_rdata !== 32'hFBFF_0400) begin
          errors++;
          $display("FAIL b2b_data1 got %h exp fbff0400", if_rdata);
        end
        if_addr = 32'h404;
      end
      if (c == 9) begin
        checks++;
        if (if_rdata !== 32'hFBFB_0404) begin
          errors++;
          $display("FAIL b2b_data2 got %h exp fbfb0404", if_rdata);
        end
        if_req = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    if_req        = 1'b0;
    if_addr       = '0;
    dm_req        = 1'b0;
    dm_we         = 1'b0;
    dm_addr       = '0;
    dm_wdata      = '0;
    l1_dm_req     = 1'b0;
    l15_dm_req    = 1'b0;
    l1_mem_rdata  = '0;
    l15_mem_rdata = '0;

    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_reset_mid_access();
    test_latency_extremes();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
